// File: rtl/clk_synth.sv
// Multi-channel fractional clock-enable synthesiser: each channel emits pulses
// at f_clk*M/D from a modulo-D phase accumulator and reports lock after LOCK_CYC pulses.
module clk_synth #(
    parameter int CH       = 2,
    parameter int W        = 16,
    parameter int LOCK_CYC = 16,
    parameter int M0       = 1,
    parameter int D0       = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   wr_en,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] wr_ch,
    input  logic [W-1:0]                           wr_m,
    input  logic [W-1:0]                           wr_d,
    output logic                                   wr_err,
    output logic [CH-1:0]                          fx_pulse,
    output logic [CH-1:0]                          fx_out,
    output logic [CH-1:0]                          locked
);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam int CW  = $clog2(LOCK_CYC + 1);
    localparam logic [CHW:0]  CH_LIM   = (CHW + 1)'(CH);
    localparam logic [CW-1:0] LAST_CNT = CW'(LOCK_CYC - 1);

    typedef enum logic [1:0] { IDLE, LOCKING, LOCKED } state_t;
    localparam state_t RST_STATE = (M0 == 0) ? IDLE : LOCKING;

    logic wr_ok;

    // M<=D keeps the accumulator below D, so W+1 bits always hold acc+M.
    assign wr_ok = wr_en && ({1'b0, wr_ch} < CH_LIM) && (wr_d != '0) && (wr_m <= wr_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_ok;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t        state, state_nx;
        logic [W-1:0]  m_q, m_nx, d_q, d_nx;
        logic [W:0]    acc, acc_nx, sum;
        logic [CW-1:0] cnt, cnt_nx;
        logic          pulse, pulse_nx, tog, tog_nx, lock, lock_nx;
        logic          hit;

        assign hit = wr_ok && (wr_ch == CHW'(i));
        assign sum = acc + {1'b0, m_q};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= RST_STATE;
                m_q   <= W'(M0);
                d_q   <= W'(D0);
                acc   <= '0;
                cnt   <= '0;
                pulse <= 1'b0;
                tog   <= 1'b0;
                lock  <= 1'b0;
            end else begin
                state <= state_nx;
                m_q   <= m_nx;
                d_q   <= d_nx;
                acc   <= acc_nx;
                cnt   <= cnt_nx;
                pulse <= pulse_nx;
                tog   <= tog_nx;
                lock  <= lock_nx;
            end
        end

        always_comb begin
            state_nx = state;
            m_nx     = m_q;
            d_nx     = d_q;
            acc_nx   = acc;
            cnt_nx   = cnt;
            pulse_nx = 1'b0;
            tog_nx   = tog;
            lock_nx  = lock;

            // A write to this channel overrides whatever pulse this edge would produce.
            if (hit) begin
                m_nx     = wr_m;
                d_nx     = wr_d;
                acc_nx   = '0;
                cnt_nx   = '0;
                tog_nx   = 1'b0;
                lock_nx  = 1'b0;
                state_nx = (wr_m == '0) ? IDLE : LOCKING;
            end else begin
                case (state)
                    LOCKING, LOCKED: begin
                        if (sum >= {1'b0, d_q}) begin
                            acc_nx   = sum - {1'b0, d_q};
                            pulse_nx = 1'b1;
                            tog_nx   = ~tog;
                            if (state == LOCKING) begin
                                cnt_nx = cnt + CW'(1);
                                if (cnt == LAST_CNT) begin
                                    state_nx = LOCKED;
                                    lock_nx  = 1'b1;
                                end
                            end
                        end else begin
                            acc_nx = sum;
                        end
                    end
                    default: begin
                        state_nx = IDLE;
                        acc_nx   = '0;
                        tog_nx   = 1'b0;
                        lock_nx  = 1'b0;
                    end
                endcase
            end
        end

        assign fx_pulse[i] = pulse;
        assign fx_out[i]   = tog;
        assign locked[i]   = lock;
    end

endmodule

// File: tb/tb_clk_synth.sv
// Self-checking bench for clk_synth: a closed-form pulse-count model checked every
// cycle, plus directed writes with hand-computed edge-exact expectations.
module tb_clk_synth;
    localparam int CH       = 3;
    localparam int W        = 16;
    localparam int LOCK_CYC = 16;
    localparam int M0       = 1;
    localparam int D0       = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_en = 1'b0;
    logic [1:0]    wr_ch = '0;
    logic [W-1:0]  wr_m  = '0;
    logic [W-1:0]  wr_d  = '0;
    logic          wr_err;
    logic [CH-1:0] fx_pulse, fx_out, locked;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    clk_synth #(
        .CH(CH), .W(W), .LOCK_CYC(LOCK_CYC), .M0(M0), .D0(D0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_m(wr_m), .wr_d(wr_d), .wr_err(wr_err),
        .fx_pulse(fx_pulse), .fx_out(fx_out), .locked(locked)
    );

    always #5 clk = ~clk;

    // Model: a running channel that has seen n edges since start has emitted floor(n*M/D) pulses.
    logic [CH-1:0][63:0] mn, mm, md;
    logic [CH-1:0]       mact;
    logic                merr;
    logic                model_ok;

    assign model_ok = wr_en && (int'(wr_ch) < CH) && (wr_d != '0) && (wr_m <= wr_d);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            merr <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                mm[i]   <= 64'(M0);
                md[i]   <= 64'(D0);
                mn[i]   <= '0;
                mact[i] <= (M0 != 0);
            end
        end else begin
            merr <= wr_en && !model_ok;
            for (int i = 0; i < CH; i++) begin
                if (model_ok && int'(wr_ch) == i) begin
                    mm[i]   <= 64'(wr_m);
                    md[i]   <= 64'(wr_d);
                    mn[i]   <= '0;
                    mact[i] <= (wr_m != '0);
                end else if (mact[i]) begin
                    mn[i] <= mn[i] + 64'd1;
                end
            end
        end
    end

    function automatic logic [63:0] pulsesAfter(int i, logic [63:0] n);
        return (n * mm[i]) / md[i];
    endfunction

    function automatic logic expPulse(int i);
        if (!mact[i] || mn[i] == 64'd0) return 1'b0;
        return pulsesAfter(i, mn[i]) != pulsesAfter(i, mn[i] - 64'd1);
    endfunction

    function automatic logic expOut(int i);
        logic [63:0] p;
        if (!mact[i]) return 1'b0;
        p = pulsesAfter(i, mn[i]);
        return p[0];
    endfunction

    function automatic logic expLock(int i);
        if (!mact[i]) return 1'b0;
        return pulsesAfter(i, mn[i]) >= 64'(LOCK_CYC);
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            checkOutput("cmp_wr_err", 8'(wr_err), 8'(merr));
            for (int i = 0; i < CH; i++) begin
                checkOutput($sformatf("cmp_pulse[%0d]", i), 8'(fx_pulse[i]), 8'(expPulse(i)));
                checkOutput($sformatf("cmp_out[%0d]", i), 8'(fx_out[i]), 8'(expOut(i)));
                checkOutput($sformatf("cmp_locked[%0d]", i), 8'(locked[i]), 8'(expLock(i)));
            end
        end
    end

    // One-cycle write; returns 1 time unit after the edge that samples it.
    task automatic applyStimulus(input int ch, input int m, input int d);
        @(negedge clk);
        #1;
        wr_en = 1'b1;
        wr_ch = 2'(ch);
        wr_m  = W'(m);
        wr_d  = W'(d);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    // Defaults M=1,D=2 after release: pulses on even edges, locked exactly at edge 32.
    task automatic checkReleaseSequence(input string tag);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            @(posedge clk);
            #2;
            if (e == 1) checkOutput({tag, "_pulse_e1"}, 8'(fx_pulse[0]), 8'd0);
            if (e == 2) checkOutput({tag, "_pulse_e2"}, 8'(fx_pulse[0]), 8'd1);
            if (e == 2) checkOutput({tag, "_out_e2"}, 8'(fx_out[0]), 8'd1);
            if (e == 4) checkOutput({tag, "_out_e4"}, 8'(fx_out[0]), 8'd0);
            if (e == 31) checkOutput({tag, "_locked_e31"}, 8'(locked), 8'd0);
            if (e == 32) checkOutput({tag, "_locked_e32"}, 8'(locked), 8'b111);
        end
    endtask

    initial begin
        #2;
        rst_n   = 1'b0;
        run_cmp = 1'b1;
        #1;
        checkOutput("rst_pulse", 8'(fx_pulse), 8'd0);
        checkOutput("rst_locked", 8'(locked), 8'd0);
        repeat (2) @(posedge clk);
        checkReleaseSequence("rel1");

        $display("[TB] ch0 M=3 D=8");
        applyStimulus(0, 3, 8);
        for (int e = 1; e <= 43; e++) begin
            @(posedge clk);
            #2;
            if (e <= 8) checkOutput($sformatf("m3d8_pulse_e%0d", e), 8'(fx_pulse[0]),
                                    8'((e == 3) || (e == 6) || (e == 8)));
            if (e == 42) checkOutput("m3d8_locked_e42", 8'(locked[0]), 8'd0);
            if (e == 43) checkOutput("m3d8_locked_e43", 8'(locked[0]), 8'd1);
            if (e == 43) checkOutput("m3d8_ch1_kept", 8'(locked[1]), 8'd1);
        end

        $display("[TB] rejected writes");
        applyStimulus(0, 5, 4);
        checkOutput("rej_m_gt_d", 8'(wr_err), 8'd1);
        applyStimulus(1, 1, 0);
        checkOutput("rej_d_zero", 8'(wr_err), 8'd1);
        applyStimulus(3, 1, 2);
        checkOutput("rej_bad_ch", 8'(wr_err), 8'd1);
        @(posedge clk);
        #1;
        checkOutput("rej_err_clear", 8'(wr_err), 8'd0);
        checkOutput("rej_locked_kept", 8'(locked), 8'b111);

        $display("[TB] ch1 stop then M=4 D=4");
        applyStimulus(1, 0, 5);
        checkOutput("stop_locked", 8'(locked[1]), 8'd0);
        checkOutput("stop_out", 8'(fx_out[1]), 8'd0);
        checkOutput("stop_err", 8'(wr_err), 8'd0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("stop_pulse_held", 8'(fx_pulse[1]), 8'd0);
        checkOutput("stop_out_held", 8'(fx_out[1]), 8'd0);
        applyStimulus(1, 4, 4);
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk);
            #2;
            checkOutput($sformatf("m4d4_pulse_e%0d", e), 8'(fx_pulse[1]), 8'd1);
            if (e == 1) checkOutput("m4d4_out_e1", 8'(fx_out[1]), 8'd1);
            if (e == 2) checkOutput("m4d4_out_e2", 8'(fx_out[1]), 8'd0);
            if (e == 15) checkOutput("m4d4_locked_e15", 8'(locked[1]), 8'd0);
            if (e == 16) checkOutput("m4d4_locked_e16", 8'(locked[1]), 8'd1);
        end

        $display("[TB] ch0 relock mid-locking");
        applyStimulus(0, 1, 3);
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            #2;
            if (e == 30) checkOutput("relock_pulse10", 8'(fx_pulse[0]), 8'd1);
            if (e == 30) checkOutput("relock_pre_locked", 8'(locked[0]), 8'd0);
        end
        applyStimulus(0, 1, 3);
        for (int e = 1; e <= 48; e++) begin
            @(posedge clk);
            #2;
            if (e == 47) checkOutput("relock_locked_e47", 8'(locked[0]), 8'd0);
            if (e == 48) checkOutput("relock_locked_e48", 8'(locked[0]), 8'd1);
        end

        $display("[TB] ch2 back-to-back writes");
        applyStimulus(2, 1, 4);
        applyStimulus(2, 1, 1);
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk);
            #2;
            if (e == 1) checkOutput("b2b_pulse_e1", 8'(fx_pulse[2]), 8'd1);
            if (e == 2) checkOutput("b2b_pulse_e2", 8'(fx_pulse[2]), 8'd1);
            if (e == 16) checkOutput("b2b_locked_e16", 8'(locked[2]), 8'd1);
        end

        $display("[TB] async reset while locked");
        @(posedge clk);
        #2;
        checkOutput("async_pre_locked", 8'(locked[2]), 8'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_pulse", 8'(fx_pulse), 8'd0);
        checkOutput("async_out", 8'(fx_out), 8'd0);
        checkOutput("async_locked", 8'(locked), 8'd0);
        checkOutput("async_err", 8'(wr_err), 8'd0);
        repeat (2) @(posedge clk);
        checkReleaseSequence("rel2");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
